// File: rtl/window_pkg.sv
// Shared definitions for the 3x3 window sequencing path: controller state
// encoding, kernel size and default coordinate widths.
package window_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int F              = 3;
    localparam int DEF_IMG_WIDTH  = 8;
    localparam int DEF_IMG_HEIGHT = 8;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int X_W = cnt_w(DEF_IMG_WIDTH);
    localparam int Y_W = cnt_w(DEF_IMG_HEIGHT);

endpackage

// File: rtl/window_ctrl_raster_counter.sv
// raster_counter: column/row position of the next pixel of a raster frame.
// inc advances one pixel, wrapping at the row end and at the frame end.
// clr returns to the origin; clr together with inc counts the current pixel
// as the origin, so the next position is (1,0).
module raster_counter
    import window_pkg::*;
#(
    parameter int COLS = DEF_IMG_WIDTH,
    parameter int ROWS = DEF_IMG_HEIGHT,
    parameter int CW   = $clog2(COLS),
    parameter int RW   = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Next position: restart, wrap at row end / frame end, or plain advance.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (inc) begin
            if (clr) begin
                col_d = CW'(1);
                row_d = '0;
            end else if (col_q == CW'(COLS - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (clr) begin
            col_d = '0;
            row_d = '0;
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign last = (col_q == CW'(COLS - 1)) && (row_q == RW'(ROWS - 1));

endmodule

// File: rtl/window_ctrl.sv
// window_ctrl: sequencing controller for the 3x3 line-buffer window
// generator. Accepts raster pixels, drives the generator clock enable
// (buf_en), flags beats whose window is a full border-free neighbourhood,
// stalls on downstream backpressure and issues one drain beat per frame.
// Optional feature: define WINDOW_CTRL_SOF_CHECK_EN to check in_sof against
// the pixel count (sticky err_sof, frame restart on an early in_sof).
module window_ctrl
    import window_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int F          = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sof,
    output logic                          buf_en,
    output logic                          win_valid,
    input  logic                          out_ready,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
    output logic                          win_last,
    output logic                          busy,
    output logic                          err_sof
);

    localparam int XW   = $clog2(IMG_WIDTH);
    localparam int YW   = $clog2(IMG_HEIGHT);
    localparam int HALF = F / 2;

    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic          pend_q, pend_d;
    logic [XW-1:0] px_q, px_d;
    logic [YW-1:0] py_q, py_d;
    logic          plast_q, plast_d;
    logic          win_valid_q, win_valid_d;
    logic [XW-1:0] win_x_q, win_x_d;
    logic [YW-1:0] win_y_q, win_y_d;
    logic          win_last_q, win_last_d;
    logic          err_q, err_d;

    logic          stall, accept, drain_fire, beat;
    logic          sof_restart, sof_missing, win_px;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          pix_last;

    raster_counter #(
        .COLS (IMG_WIDTH),
        .ROWS (IMG_HEIGHT),
        .CW   (XW),
        .RW   (YW)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (sof_restart),
        .inc  (accept),
        .col  (col),
        .row  (row),
        .last (pix_last)
    );

    // Handshake and beat generation; a held window freezes the whole path.
    always_comb begin
        stall      = win_valid_q && !out_ready;
        in_ready   = !rst && (state_q != ST_DRAIN) && !stall;
        accept     = in_valid && in_ready;
        drain_fire = !rst && (state_q == ST_DRAIN) && !stall;
        beat       = accept || drain_fire;
        buf_en     = beat;
    end

`ifdef WINDOW_CTRL_SOF_CHECK_EN
    // Frame-start check: early in_sof restarts the frame, missing in_sof is flagged.
    always_comb begin
        sof_restart = accept && in_sof && ((col != '0) || (row != '0));
        sof_missing = accept && (state_q == ST_IDLE) && !in_sof;
    end
`else
    logic unused_sof;
    assign unused_sof = in_sof;

    // Frames are delimited by counting only.
    always_comb begin
        sof_restart = 1'b0;
        sof_missing = 1'b0;
    end
`endif

    // Pending-window latch and output window registers.
    always_comb begin
        win_px      = !sof_restart && (col >= XW'(F - 1)) && (row >= YW'(F - 1));
        pend_d      = pend_q;
        px_d        = px_q;
        py_d        = py_q;
        plast_d     = plast_q;
        win_valid_d = win_valid_q;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;
        win_last_d  = win_last_q;
        err_d       = err_q || sof_restart || sof_missing;
        if (beat) begin
            pend_d = accept && win_px;
        end
        if (accept) begin
            px_d    = col - XW'(HALF);
            py_d    = row - YW'(HALF);
            plast_d = pix_last;
        end
        // The pending pixel reaches the bottom-right tap on the next beat.
        if (beat && pend_q) begin
            win_valid_d = 1'b1;
            win_x_d     = px_q;
            win_y_d     = py_q;
            win_last_d  = plast_q;
        end else if (out_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // Next-state logic: IDLE -> RUN on first pixel, RUN -> DRAIN on last pixel.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_RUN;
            ST_RUN:   if (accept && pix_last && !sof_restart) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_fire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, flags and window registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
            plast_q     <= 1'b0;
            win_valid_q <= 1'b0;
            win_x_q     <= '0;
            win_y_q     <= '0;
            win_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            px_q        <= px_d;
            py_q        <= py_d;
            plast_q     <= plast_d;
            win_valid_q <= win_valid_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
            win_last_q  <= win_last_d;
            err_q       <= err_d;
        end
    end

    assign win_valid = win_valid_q;
    assign win_x     = win_x_q;
    assign win_y     = win_y_q;
    assign win_last  = win_last_q;
    assign busy      = busy_q;
    assign err_sof   = err_q;

endmodule

// File: tb/tb_window_ctrl.sv
// Self-checking bench for window_ctrl (8x8 frame). Expected windows are
// queued as pixels are accepted and compared when the window is consumed.
module tb_window_ctrl;

    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, buf_en, win_valid, win_last, busy, err_sof;
    logic [2:0] win_x, win_y;

    always #5 clk = ~clk;

    window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .F(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .buf_en    (buf_en),
        .win_valid (win_valid),
        .out_ready (out_ready),
        .win_x     (win_x),
        .win_y     (win_y),
        .win_last  (win_last),
        .busy      (busy),
        .err_sof   (err_sof)
    );

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic       l;
    } win_t;

    win_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    // reference model of the controller
    int mstate = 0;
    int mcol = 0;
    int mrow = 0;
    bit mpend = 0;
    bit mwv = 0;
    bit merr = 0;

    int windows, lasts, beats, first_beat, last_beat, bubbles, acc_cnt;
    int sof_at = -1;
    bit count_bub = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        windows = 0; lasts = 0; beats = 0; first_beat = -1; last_beat = -1;
        bubbles = 0; acc_cnt = 0;
    endtask

    task automatic tick(input bit v, input bit o, input bit r);
        bit stall, e_rdy, acc, dfire, beat, sofr, lastpx;
        win_t w;
        @(negedge clk);
        rst = r;
        in_valid = v;
        out_ready = o;
        in_sof = (sof_at >= 0 && acc_cnt == sof_at) ? 1'b1 : (mcol == 0 && mrow == 0);
        #1;
        stall = mwv && !o;
        e_rdy = !r && (mstate != 2) && !stall;
        acc   = v && e_rdy;
        dfire = !r && (mstate == 2) && !stall;
        beat  = acc || dfire;
        chk("in_ready", in_ready, e_rdy);
        chk("buf_en", buf_en, beat);
        chk("win_valid", win_valid, mwv);
        chk("busy", busy, mstate != 0);
        chk("err_sof", err_sof, merr);
        if (!r && win_valid === 1'b1 && first_beat < 0) first_beat = beats;
        if (!r && win_valid === 1'b1 && win_last === 1'b1 && last_beat < 0) last_beat = beats;
        if (count_bub && v && o && !r && in_ready !== 1'b1) bubbles++;
        if (mwv && o) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1);
            end else begin
                w = sb.pop_front();
                chk("win_x", win_x, w.x);
                chk("win_y", win_y, w.y);
                chk("win_last", win_last, w.l);
                windows++;
                if (win_last === 1'b1) lasts++;
            end
        end
        if (!r && buf_en === 1'b1) beats++;
        // advance the model across the coming clock edge
        if (r) begin
            mstate = 0; mcol = 0; mrow = 0; mpend = 0; mwv = 0; merr = 0;
            sb.delete();
        end else begin
            lastpx = (mcol == W - 1) && (mrow == H - 1);
            sofr = 0;
`ifdef WINDOW_CTRL_SOF_CHECK_EN
            if (acc && in_sof && (mcol != 0 || mrow != 0)) begin
                sofr = 1; merr = 1;
            end
            if (acc && mstate == 0 && !in_sof) merr = 1;
`endif
            if (beat && mpend) mwv = 1;
            else if (o) mwv = 0;
            if (beat) begin
                if (acc && !sofr && mcol >= 2 && mrow >= 2) begin
                    mpend = 1;
                    w.x = 3'(mcol - 1);
                    w.y = 3'(mrow - 1);
                    w.l = lastpx;
                    sb.push_back(w);
                end else begin
                    mpend = 0;
                end
            end
            case (mstate)
                0: if (acc) mstate = 1;
                1: if (acc && lastpx && !sofr) mstate = 2;
                default: if (dfire) mstate = 0;
            endcase
            if (acc) begin
                acc_cnt++;
                if (sofr) begin
                    mcol = 1; mrow = 0;
                end else if (mcol == W - 1) begin
                    mcol = 0;
                    mrow = (mrow == H - 1) ? 0 : mrow + 1;
                end else begin
                    mcol++;
                end
            end
        end
    endtask

    task automatic run_pixels(input int n, input bit rnd, input bit tog);
        int target = acc_cnt + n;
        int budget = n * 4 + 100;
        bit ph = 1;
        while (acc_cnt < target && budget > 0) begin
            tick(rnd ? 1'($urandom_range(0, 1)) : 1'b1, tog ? ph : 1'b1, 1'b0);
            ph = !ph;
            budget--;
        end
        chk("pixels_accepted", acc_cnt, target);
    endtask

    task automatic flush(input bit tog);
        int budget = 200;
        bit ph = 1;
        bit done;
        done = (mstate == 0) && !mwv && (sb.size() == 0);
        while (!done && budget > 0) begin
            tick(1'b0, tog ? ph : 1'b1, 1'b0);
            ph = !ph;
            budget--;
            done = (mstate == 0) && !mwv && (sb.size() == 0);
        end
        chk("flush_done", done, 1);
    endtask

    task automatic chk_reset_regs();
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_x", win_x, 0);
        chk("rst_win_y", win_y, 0);
        chk("rst_win_last", win_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_sof", err_sof, 0);
        chk("rst_buf_en", buf_en, 0);
        chk("rst_in_ready", in_ready, 0);
    endtask

    initial begin
        clr_stats();
        // reset
        repeat (3) tick(1'b1, 1'b1, 1'b1);
        #5;
        chk_reset_regs();

        // full-speed frame
        clr_stats();
        run_pixels(64, 1'b0, 1'b0);
        flush(1'b0);
        chk("t1_windows", windows, 36);
        chk("t1_lasts", lasts, 1);
        chk("t1_first_beat", first_beat, 20);
        chk("t1_last_beat", last_beat, 65);

        // toggling backpressure
        clr_stats();
        run_pixels(64, 1'b0, 1'b1);
        flush(1'b1);
        chk("t2_windows", windows, 36);
        chk("t2_lasts", lasts, 1);

        // random input valid
        clr_stats();
        run_pixels(64, 1'b1, 1'b0);
        flush(1'b0);
        chk("t3_windows", windows, 36);
        chk("t3_beats", beats, 65);

        // reset mid-frame, then a full frame
        clr_stats();
        run_pixels(30, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        #5;
        chk_reset_regs();
        clr_stats();
        run_pixels(64, 1'b0, 1'b0);
        flush(1'b0);
        chk("t4_windows", windows, 36);
        chk("t4_lasts", lasts, 1);

        // two back-to-back frames
        clr_stats();
        count_bub = 1;
        run_pixels(128, 1'b0, 1'b0);
        count_bub = 0;
        chk("t5_bubbles", bubbles, 1);
        flush(1'b0);
        chk("t5_windows", windows, 72);
        chk("t5_lasts", lasts, 2);

        // in_sof on the 10th pixel
        clr_stats();
        sof_at = 9;
`ifdef WINDOW_CTRL_SOF_CHECK_EN
        run_pixels(73, 1'b0, 1'b0);
        sof_at = -1;
        flush(1'b0);
        chk("t6_err_sof", err_sof, 1);
`else
        run_pixels(64, 1'b0, 1'b0);
        sof_at = -1;
        flush(1'b0);
        chk("t6_err_sof", err_sof, 0);
`endif
        chk("t6_windows", windows, 36);
        chk("t6_lasts", lasts, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
